// File: rtl/hyperbus_addr_map_if.sv
// hyperbus_addr_map_if: config register port and decode request/response bundle.
// slave: decoder side (hyperbus_addr_map); master: front-end / config side.
interface hyperbus_addr_map_if #(
  parameter int NumPhys   = 1,
  parameter int NumChips  = 2,
  parameter int AddrWidth = 48,
  parameter int RegAw     = $clog2(4*NumPhys*NumChips+1)
);
  localparam int PhyW = NumPhys > 1 ? $clog2(NumPhys) : 1;
  logic                 reg_valid_i;
  logic                 reg_write_i;
  logic [RegAw-1:0]     reg_addr_i;
  logic [31:0]          reg_wdata_i;
  logic                 reg_ready_o;
  logic [31:0]          reg_rdata_o;
  logic                 reg_error_o;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [AddrWidth-1:0] req_addr_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [PhyW-1:0]      rsp_phy_o;
  logic [NumChips-1:0]  rsp_cs_o;
  logic [AddrWidth-1:0] rsp_offset_o;
  logic                 rsp_err_o;
  modport slave (
    input  reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i, req_valid_i, req_addr_i, rsp_ready_i,
    output reg_ready_o, reg_rdata_o, reg_error_o, req_ready_o,
           rsp_valid_o, rsp_phy_o, rsp_cs_o, rsp_offset_o, rsp_err_o
  );
  modport master (
    output reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i, req_valid_i, req_addr_i, rsp_ready_i,
    input  reg_ready_o, reg_rdata_o, reg_error_o, req_ready_o,
           rsp_valid_o, rsp_phy_o, rsp_cs_o, rsp_offset_o, rsp_err_o
  );
endinterface

// File: rtl/hyperbus_addr_map.sv
// hyperbus_addr_map: runtime-programmable PHY/chip-select address decoder with atomic rule commit.
// Ports: clk_i, rst_i (async, active-high); bus (slave) carries the config register port
// (reg_*) and the one-stage decode pipeline (req_* in, rsp_* out).
module hyperbus_addr_map #(
  parameter int                   NumPhys      = 1,
  parameter int                   NumChips     = 2,
  parameter int                   AddrWidth    = 48,
  parameter logic [AddrWidth-1:0] RstBase      = 'h4000_0000,
  parameter logic [AddrWidth-1:0] RstChipBytes = 'h80_0000,
  parameter int                   RegAw        = $clog2(4*NumPhys*NumChips+1)
) (
  input logic                clk_i,
  input logic                rst_i,
  hyperbus_addr_map_if.slave bus
);
  localparam int NumRules = NumPhys*NumChips;
  localparam int PhyW     = NumPhys > 1 ? $clog2(NumPhys) : 1;
  localparam int IdxW     = RegAw-2;
  localparam logic [RegAw-1:0] CtrlIdx = RegAw'(4*NumRules);
  typedef enum logic [1:0] {IDLE, DRAIN, APPLY} state_t;
  state_t               r_state;
  logic [AddrWidth-1:0] r_sh_start [NumRules];
  logic [AddrWidth-1:0] r_sh_end   [NumRules];
  logic [AddrWidth-1:0] r_act_start[NumRules];
  logic [AddrWidth-1:0] r_act_end  [NumRules];
  logic                 r_en, r_rsp_valid, r_err;
  logic [PhyW-1:0]      r_phy;
  logic [NumChips-1:0]  r_cs;
  logic [AddrWidth-1:0] r_off;
  logic [IdxW-1:0]      w_idx;
  logic [1:0]           w_sel;
  logic                 w_in_rules, w_is_ctrl, w_pending, w_sh_wr, w_ctrl_wr, w_req_acc, w_hit;
  logic [31:0]          w_rdata;
  logic [PhyW-1:0]      w_phy;
  logic [NumChips-1:0]  w_cs;
  logic [AddrWidth-1:0] w_off;
  assign w_idx      = bus.reg_addr_i[RegAw-1:2];
  assign w_sel      = bus.reg_addr_i[1:0];
  assign w_in_rules = bus.reg_addr_i < CtrlIdx;
  assign w_is_ctrl  = bus.reg_addr_i == CtrlIdx;
  assign w_pending  = r_state != IDLE;
  assign w_sh_wr    = bus.reg_valid_i && bus.reg_write_i && w_in_rules;
  assign w_ctrl_wr  = bus.reg_valid_i && bus.reg_write_i && w_is_ctrl;
  // Shadow writes stall until the pending commit has copied the shadow set.
  assign bus.reg_ready_o  = !(w_pending && w_sh_wr);
  assign bus.reg_error_o  = bus.reg_valid_i && bus.reg_addr_i > CtrlIdx;
  assign bus.reg_rdata_o  = w_rdata;
  assign bus.req_ready_o  = r_state == IDLE && (!r_rsp_valid || bus.rsp_ready_i);
  assign w_req_acc        = bus.req_valid_i && bus.req_ready_o;
  assign bus.rsp_valid_o  = r_rsp_valid;
  assign bus.rsp_phy_o    = r_phy;
  assign bus.rsp_cs_o     = r_cs;
  assign bus.rsp_offset_o = r_off;
  assign bus.rsp_err_o    = r_err;
  always_comb begin
    w_rdata = w_is_ctrl ? {30'd0, w_pending, r_en} : '0;
    for (int i = 0; i < NumRules; i++)
      if (w_in_rules && w_idx == IdxW'(i))
        w_rdata = w_sel == 2'd0 ? r_sh_start[i][31:0] :
                  w_sel == 2'd1 ? 32'(r_sh_start[i][AddrWidth-1:32]) :
                  w_sel == 2'd2 ? r_sh_end[i][31:0] : 32'(r_sh_end[i][AddrWidth-1:32]);
  end
  // Scan high to low so the lowest matching rule is the one left standing.
  // start <= addr < end already rules out windows with end <= start.
  always_comb begin
    w_hit = 1'b0;
    w_phy = '0;
    w_cs  = '0;
    w_off = '0;
    for (int i = NumRules-1; i >= 0; i--)
      if (r_en && bus.req_addr_i >= r_act_start[i] && bus.req_addr_i < r_act_end[i]) begin
        w_hit = 1'b1;
        w_phy = PhyW'(i / NumChips);
        w_cs  = NumChips'(1) << (i % NumChips);
        w_off = bus.req_addr_i - r_act_start[i];
      end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state     <= IDLE;
      r_en        <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_phy       <= '0;
      r_cs        <= '0;
      r_off       <= '0;
      for (int i = 0; i < NumRules; i++) begin
        r_sh_start[i]  <= RstBase + AddrWidth'(i) * RstChipBytes;
        r_sh_end[i]    <= RstBase + AddrWidth'(i+1) * RstChipBytes;
        r_act_start[i] <= RstBase + AddrWidth'(i) * RstChipBytes;
        r_act_end[i]   <= RstBase + AddrWidth'(i+1) * RstChipBytes;
      end
    end else begin
      if (w_req_acc) begin
        r_rsp_valid <= 1'b1;
        r_err       <= !w_hit;
        r_phy       <= w_phy;
        r_cs        <= w_cs;
        r_off       <= w_off;
      end else if (bus.rsp_ready_i)
        r_rsp_valid <= 1'b0;
      if (w_ctrl_wr)
        r_en <= bus.reg_wdata_i[0];
      for (int i = 0; i < NumRules; i++)
        if (w_sh_wr && !w_pending && w_idx == IdxW'(i)) begin
          if (w_sel == 2'd0) r_sh_start[i][31:0] <= bus.reg_wdata_i;
          if (w_sel == 2'd1) r_sh_start[i][AddrWidth-1:32] <= bus.reg_wdata_i[AddrWidth-33:0];
          if (w_sel == 2'd2) r_sh_end[i][31:0] <= bus.reg_wdata_i;
          if (w_sel == 2'd3) r_sh_end[i][AddrWidth-1:32] <= bus.reg_wdata_i[AddrWidth-33:0];
        end
      case (r_state)
        IDLE:  if (w_ctrl_wr && bus.reg_wdata_i[1]) r_state <= DRAIN;
        DRAIN: if (!r_rsp_valid || bus.rsp_ready_i) r_state <= APPLY;
        APPLY: begin
          r_act_start <= r_sh_start;
          r_act_end   <= r_sh_end;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: doc/hyperbus_addr_map.md
Name: hyperbus_addr_map

Overview:
- Runtime-programmable address decoder placed between the Hyperbus AXI front-end and the PHY/chip-select logic.
- Generalises the static per-chip address rules to NumPhys x NumChips rules, each with a start and end address.
- Rules live in shadow registers, written over a register-bus-style port, and take effect through an atomic commit.
- Incoming addresses pass through a one-stage valid/ready pipeline and return PHY index, one-hot chip select, in-chip offset and a miss error.

Parameters:
- NumPhys, 1, number of Hyperbus PHYs.
- NumChips, 2, chips per PHY; NumRules = NumPhys*NumChips.
- AddrWidth, 48, request and rule address width.
- RstBase, 'h4000_0000, reset start address of rule 0.
- RstChipBytes, 'h80_0000, reset size of each rule window.
- RegAw, $clog2(4*NumRules+1), config word-index width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- reg_valid_i  in  1  config access request.
- reg_write_i  in  1  1 = write, 0 = read.
- reg_addr_i  in  RegAw  32-bit word index.
- reg_wdata_i  in  32  write data.
- reg_ready_o  out  1  access accepted this cycle.
- reg_rdata_o  out  32  read data, valid when reg_valid_i && reg_ready_o.
- reg_error_o  out  1  access is out of range.
- req_valid_i  in  1  decode request valid.
- req_ready_o  out  1  decode request accepted.
- req_addr_i  in  AddrWidth  address to decode.
- rsp_valid_o  out  1  decode result valid.
- rsp_ready_i  in  1  result consumed.
- rsp_phy_o  out  max(1,$clog2(NumPhys))  matched PHY.
- rsp_cs_o  out  NumChips  one-hot chip select; all zero on error.
- rsp_offset_o  out  AddrWidth  req_addr minus the matched rule start.
- rsp_err_o  out  1  no enabled rule matched.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high, ports named clk_i and rst_i.
- Register map, per rule i (NumRules entries):
  - word 4i: start[31:0]
  - word 4i+1: start[AddrWidth-1:32]
  - word 4i+2: end[31:0]
  - word 4i+3: end[AddrWidth-1:32]
  - All four words address the shadow copy.
- Control word at 4*NumRules:
  - bit0 enable, written directly to the active copy.
  - bit1 commit, write 1 to set, self-clearing, reads 1 while pending.
  - Other bits read 0.
- Config reads:
  - Combinational, same cycle.
  - Reads return shadow values; unused upper start/end bits read 0.
- Out-of-range word index: reg_ready_o=1, reg_error_o=1, reg_rdata_o=0, no state change.
- reg_ready_o = 0 while a commit is pending and the access is a shadow write; 1 otherwise.
- Reset values:
  - Rule i = p*NumChips+c: start = RstBase + i*RstChipBytes, end = start + RstChipBytes, in both shadow and active copies.
  - enable = 1, commit = 0.
  - rsp_valid_o = 0 and all rsp_* outputs = 0.
- Commit FSM:
  - States: IDLE, DRAIN, APPLY.
  - IDLE -> DRAIN on a commit write. During DRAIN, req_ready_o = 0.
  - DRAIN -> APPLY when rsp_valid_o = 0, or when rsp_valid_o && rsp_ready_i.
  - APPLY (one cycle): copy all shadow rules to active, clear commit, return to IDLE.
  - The first request after the commit can be accepted in the cycle after APPLY.
- Decode:
  - Rule i matches iff active start_i < end_i and start_i <= addr < end_i. Comparisons are unsigned, full AddrWidth.
  - A rule with end <= start never matches.
  - If several rules match, the lowest index wins.
  - If enable = 0, every request returns err = 1.
  - On a match: phy = i / NumChips, cs = 1 << (i % NumChips), offset = addr - start_i.
  - On a miss: err = 1, cs = 0, phy = 0, offset = 0.
- Pipeline:
  - req_ready_o = (state == IDLE) && (!rsp_valid_o || rsp_ready_i).
  - The result is registered on req_valid_i && req_ready_o, giving one cycle of latency.
  - rsp_* outputs stay stable while rsp_valid_o && !rsp_ready_i.
  - Full throughput: one decode per cycle when rsp_ready_i = 1.
- Simultaneous events:
  - A commit write and a request accept in the same cycle: the request uses the old active rules.
  - A shadow write during APPLY is stalled (commit still pending).
- Reset mid-operation: reset restores all reset values immediately; a pending commit and an in-flight result are discarded.

Test Plan:
- Default map (NumPhys=1, NumChips=2): decode after reset.
  - 0x4000_0000 -> cs=01, offset=0, err=0.
  - 0x4080_0010 -> cs=10, offset=0x10.
  - 0x4100_0000 -> err=1, cs=00.
  - 0x3FFF_FFFF -> err=1.
- Back-pressure:
  - Issue 0x4000_0008 with rsp_ready_i=0 for 3 cycles -> rsp held stable, req_ready_o=0.
  - Raise rsp_ready_i -> the next request 0x4080_0000 is accepted in the same cycle and its result appears the next cycle with cs=10.
- Commit:
  - Write rule0 start=0x5000_0000, end=0x5100_0000 -> a decode of 0x5000_0040 still errs.
  - Set commit while a result is stalled -> reg_ready_o=0 for shadow writes and req_ready_o=0 until the result drains, then APPLY.
  - After APPLY, 0x5000_0040 -> cs=01, offset=0x40, and the control word reads commit=0.
- Priority and invalid rules:
  - Rule1 = [0x5000_0000, 0x6000_0000), committed -> 0x5000_0000 hits rule0.
  - Rule0 end = start = 0x5000_0000, committed -> 0x5000_0000 hits rule1 with cs=10.
- Enable and config errors:
  - enable=0 -> every request returns err=1.
  - Read of word index 9 -> reg_error_o=1, rdata=0.
  - Write to word index 9 -> no register changes.
- Reset during DRAIN with a stalled result:
  - Assert rst_i -> rsp_valid_o=0 asynchronously and reset windows are restored.
  - After release, 0x4000_0000 -> cs=01.
